mmsa_seq_ctrl: RTL and testbench

- Sequencer for the matrix-multiply systolic array (MMSA) datapath.
- Accepts one job: size code, input-matrix index and weight-matrix index, all already deserialized.
- Drives the row-organised input/weight SRAMs and the array's weight-load and feed enables, waits out the pipeline, then hands 2N-1 diagonal-sum results one at a time to the serial output shifter.
- Sits between the input deserializer and the array/SRAM/output serializer.

---
 rtl/mmsa_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mmsa_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmsa_seq_ctrl.sv
// mmsa_seq_ctrl -- job sequencer for the matrix-multiply systolic array.
//
// Takes one job (size code plus input/weight matrix indices) and runs it.
// First it streams N weight rows out of the weight SRAM into the array.
// Then it streams N input rows out of the input SRAM into the array.
// It waits for the array pipeline to drain.
// Finally it hands the 2N-1 diagonal sums to the output serializer, one at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job request (ignored unless idle)
//   matrix_size           size code: N = 2 << matrix_size
//   i_mat_idx, w_mat_idx  input / weight matrix index
//   busy, done            job in progress / one-cycle end-of-job pulse
//   w_rd, w_addr          weight SRAM read, address {w_idx, row}
//   i_rd, i_addr          input SRAM read, address {i_idx, row}
//   w_load_en, w_load_row array latches weight row (SRAM_LAT after w_rd)
//   i_feed_en, i_feed_row array accepts input row (SRAM_LAT after i_rd)
//   acc_clr               one-cycle accumulator clear at job start
//   out_start, out_sel    serializer request and diagonal index
//   out_done              serializer finished the current value
module mmsa_seq_ctrl #(
    parameter int unsigned MAX_N      = 16,
    parameter int unsigned SRAM_LAT   = 1,
    parameter int unsigned PIPE_EXTRA = 1,
    localparam int unsigned IW = $clog2(MAX_N),
    localparam int unsigned SW = $clog2(2 * MAX_N - 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      matrix_size,
    input  logic [IW-1:0]   i_mat_idx,
    input  logic [IW-1:0]   w_mat_idx,
    output logic            busy,
    output logic            done,
    output logic            w_rd,
    output logic [2*IW-1:0] w_addr,
    output logic            i_rd,
    output logic [2*IW-1:0] i_addr,
    output logic            w_load_en,
    output logic [IW-1:0]   w_load_row,
    output logic            i_feed_en,
    output logic [IW-1:0]   i_feed_row,
    output logic            acc_clr,
    output logic            out_start,
    output logic [SW-1:0]   out_sel,
    input  logic            out_done
);

    localparam int unsigned CW = $clog2(2 * MAX_N + PIPE_EXTRA + SRAM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DRAIN,
        S_OUT_PULSE,
        S_OUT_WAIT,
        S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] diag, diag_nxt;
    logic [IW-1:0] n_m1, w_idx, i_idx;
    logic [IW-1:0] row;
    logic [CW-1:0] n_m1_w, drain_last;
    logic [SW-1:0] diag_last;

    assign row        = cnt[IW-1:0];
    assign n_m1_w     = CW'(n_m1);
    // DRAIN lasts 2N-1+PIPE_EXTRA+SRAM_LAT cycles; the counter runs from 0
    // up to and including drain_last.
    assign drain_last = (n_m1_w << 1) + CW'(PIPE_EXTRA + SRAM_LAT);
    assign diag_last  = SW'(n_m1) << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            diag  <= '0;
            n_m1  <= '0;
            w_idx <= '0;
            i_idx <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            diag  <= diag_nxt;
            if (state == S_IDLE && start) begin
                n_m1  <= IW'((2 << matrix_size) - 1);
                w_idx <= w_mat_idx;
                i_idx <= i_mat_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        diag_nxt  = diag;
        busy      = 1'b0;
        done      = 1'b0;
        w_rd      = 1'b0;
        w_addr    = '0;
        i_rd      = 1'b0;
        i_addr    = '0;
        acc_clr   = 1'b0;
        out_start = 1'b0;
        out_sel   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD_W;
                    cnt_nxt   = '0;
                    diag_nxt  = '0;
                end
            end
            S_LOAD_W: begin
                busy    = 1'b1;
                w_rd    = 1'b1;
                w_addr  = {w_idx, row};
                acc_clr = (cnt == '0);
                if (cnt == n_m1_w) begin
                    state_nxt = S_FEED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_FEED: begin
                busy   = 1'b1;
                i_rd   = 1'b1;
                i_addr = {i_idx, row};
                if (cnt == n_m1_w) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (cnt == drain_last) begin
                    state_nxt = S_OUT_PULSE;
                    cnt_nxt   = '0;
                    diag_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_OUT_PULSE: begin
                // out_done during the request cycle is deliberately not looked at
                busy      = 1'b1;
                out_start = 1'b1;
                out_sel   = diag;
                state_nxt = S_OUT_WAIT;
            end
            S_OUT_WAIT: begin
                busy    = 1'b1;
                out_sel = diag;
                if (out_done) begin
                    if (diag == diag_last) begin
                        state_nxt = S_FIN;
                    end else begin
                        diag_nxt  = diag + SW'(1);
                        state_nxt = S_OUT_PULSE;
                    end
                end
            end
            S_FIN: begin
                done      = 1'b1;
                diag_nxt  = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM read-latency alignment: shift registers carry the read strobe and
    // row index forward so the array sees them exactly SRAM_LAT cycles later.
    // The weight tail runs on into FEED, and the input tail runs on into DRAIN.
    logic [SRAM_LAT-1:0]    w_en_q, i_en_q;
    logic [SRAM_LAT*IW-1:0] w_row_q, i_row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q  <= '0;
            i_en_q  <= '0;
            w_row_q <= '0;
            i_row_q <= '0;
        end else begin
            w_en_q  <= SRAM_LAT'({w_en_q, w_rd});
            i_en_q  <= SRAM_LAT'({i_en_q, i_rd});
            w_row_q <= (SRAM_LAT*IW)'({w_row_q, (w_rd ? row : {IW{1'b0}})});
            i_row_q <= (SRAM_LAT*IW)'({i_row_q, (i_rd ? row : {IW{1'b0}})});
        end
    end

    assign w_load_en  = w_en_q[SRAM_LAT-1];
    assign i_feed_en  = i_en_q[SRAM_LAT-1];
    assign w_load_row = w_row_q[SRAM_LAT*IW-1 -: IW];
    assign i_feed_row = i_row_q[SRAM_LAT*IW-1 -: IW];

endmodule

// File: tb/tb_mmsa_seq_ctrl.sv
// tb_mmsa_seq_ctrl -- scoreboard bench for mmsa_seq_ctrl.
// A job launch pushes the timeline of the load/feed/drain phase.
// A serializer model pushes each follow-up out_start or done.
// The monitor pops and compares one entry per cycle in which the DUT shows activity.
module tb_mmsa_seq_ctrl;

    localparam int SL = 1;
    localparam int PE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [1:0] matrix_size = '0;
    logic [3:0] i_mat_idx = '0;
    logic [3:0] w_mat_idx = '0;
    logic       busy, done, w_rd, i_rd, w_load_en, i_feed_en, acc_clr, out_start;
    logic [7:0] w_addr, i_addr;
    logic [3:0] w_load_row, i_feed_row;
    logic [4:0] out_sel;
    logic       out_done = 1'b0;

    mmsa_seq_ctrl #(.MAX_N(16), .SRAM_LAT(SL), .PIPE_EXTRA(PE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
        .i_mat_idx(i_mat_idx), .w_mat_idx(w_mat_idx), .busy(busy), .done(done),
        .w_rd(w_rd), .w_addr(w_addr), .i_rd(i_rd), .i_addr(i_addr),
        .w_load_en(w_load_en), .w_load_row(w_load_row), .i_feed_en(i_feed_en),
        .i_feed_row(i_feed_row), .acc_clr(acc_clr), .out_start(out_start),
        .out_sel(out_sel), .out_done(out_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       acc_clr;
        logic       w_rd;
        logic [7:0] w_addr;
        logic       i_rd;
        logic [7:0] i_addr;
        logic       w_load_en;
        logic [3:0] w_load_row;
        logic       i_feed_en;
        logic [3:0] i_feed_row;
        logic       out_start;
        logic [4:0] out_sel;
    } obs_t;

    typedef struct {
        int   at;
        obs_t v;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int jobs_done = 0;
    int ostarts = 0;
    int ser_d = 0;
    int last_d = 0;
    int cur_n = 2;
    int cur_dr = 5;
    logic [1:0] cur_sz;
    logic [3:0] cur_wi, cur_ii;
    bit ser_hold40 = 1'b0;
    bit kill = 1'b0;

    task automatic chk(input bit ok, input string name, input string det);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s %s", name, det);
        end
    endtask

    // Address/row/sel fields only carry meaning while their strobe is high.
    function automatic obs_t sample();
        obs_t o;
        o.busy       = busy;
        o.done       = done;
        o.acc_clr    = acc_clr;
        o.w_rd       = w_rd;
        o.w_addr     = w_rd ? w_addr : 8'h0;
        o.i_rd       = i_rd;
        o.i_addr     = i_rd ? i_addr : 8'h0;
        o.w_load_en  = w_load_en;
        o.w_load_row = w_load_en ? w_load_row : 4'h0;
        o.i_feed_en  = i_feed_en;
        o.i_feed_row = i_feed_en ? i_feed_row : 4'h0;
        o.out_start  = out_start;
        o.out_sel    = out_start ? out_sel : 5'h0;
        return o;
    endfunction

    function automatic bit all_zero();
        return ({busy, done, w_rd, w_addr, i_rd, i_addr, w_load_en, w_load_row,
                 i_feed_en, i_feed_row, acc_clr, out_start, out_sel} == '0);
    endfunction

    // Monitor: every cycle with any strobe high must match the scoreboard head.
    obs_t mon_a;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].at < cyc) begin
                mon_e = q.pop_front();
                chk(1'b0, "missing_event", $sformatf("cyc=%0d got=none exp=%h", mon_e.at, mon_e.v));
            end
            mon_a = sample();
            if (w_rd | i_rd | w_load_en | i_feed_en | acc_clr | out_start | done) begin
                if (out_start) ostarts++;
                if (q.size() > 0 && q[0].at == cyc) begin
                    mon_e = q.pop_front();
                    chk(mon_a == mon_e.v, "event", $sformatf("cyc=%0d got=%h exp=%h", cyc, mon_a, mon_e.v));
                    if (mon_e.v.done) jobs_done++;
                end else begin
                    chk(1'b0, "unexpected_event", $sformatf("cyc=%0d got=%h exp=none", cyc, mon_a));
                end
            end
        end
    end

    // Serializer model: random hold per value, occasionally a stray out_done in the request cycle.
    int   ser_cur, ser_hold, ser_k;
    exp_t ser_e;
    initial begin
        forever begin
            @(negedge clk);
            out_done = 1'b0;
            if (out_start && rst_n && !kill) begin
                ser_cur  = ser_d;
                ser_hold = ser_hold40 ? 40 : int'($urandom_range(1, 4));
                if ($urandom_range(0, 2) == 0) out_done = 1'b1;
                ser_k = 0;
                while (ser_k < ser_hold && !kill) begin
                    @(negedge clk);
                    out_done = 1'b0;
                    ser_k++;
                    if (!kill) begin
                        chk(out_sel == 5'(ser_cur), "out_sel_hold",
                            $sformatf("cyc=%0d got=%0d exp=%0d", cyc, out_sel, ser_cur));
                        chk(!out_start, "no_extra_out_start",
                            $sformatf("cyc=%0d got=%0b exp=0", cyc, out_start));
                    end
                end
                if (!kill) begin
                    out_done = 1'b1;
                    ser_e.at = cyc + 1;
                    ser_e.v  = '0;
                    if (ser_cur < last_d) begin
                        ser_e.v.busy      = 1'b1;
                        ser_e.v.out_start = 1'b1;
                        ser_e.v.out_sel   = 5'(ser_cur + 1);
                        ser_d             = ser_cur + 1;
                    end else begin
                        ser_e.v.done = 1'b1;
                    end
                    q.push_back(ser_e);
                end
            end
        end
    end

    // Launch a job and push its timeline up to the first out_start.
    // Offset o=1 is the first cycle after the edge that samples start.
    task automatic launch(input logic [1:0] sz, input logic [3:0] wi, input logic [3:0] ii);
        int   n, dr, s;
        obs_t v;
        exp_t e;
        n  = 2 << sz;
        dr = 2 * n - 1 + PE + SL;
        @(negedge clk);
        s = cyc;
        cur_n = n; cur_dr = dr; cur_sz = sz; cur_wi = wi; cur_ii = ii;
        ser_d = 0; last_d = 2 * n - 2; ostarts = 0;
        start = 1'b1; matrix_size = sz; w_mat_idx = wi; i_mat_idx = ii;
        for (int o = 1; o <= 2 * n + dr + 1; o++) begin
            v = '0;
            v.busy = 1'b1;
            if (o == 1) v.acc_clr = 1'b1;
            if (o <= n) begin
                v.w_rd = 1'b1; v.w_addr = {wi, 4'(o - 1)};
            end
            if (o > SL && o <= n + SL) begin
                v.w_load_en = 1'b1; v.w_load_row = 4'(o - 1 - SL);
            end
            if (o > n && o <= 2 * n) begin
                v.i_rd = 1'b1; v.i_addr = {ii, 4'(o - n - 1)};
            end
            if (o > n + SL && o <= 2 * n + SL) begin
                v.i_feed_en = 1'b1; v.i_feed_row = 4'(o - n - 1 - SL);
            end
            if (o == 2 * n + dr + 1) v.out_start = 1'b1;
            if (v.acc_clr | v.w_rd | v.i_rd | v.w_load_en | v.i_feed_en | v.out_start) begin
                e.at = s + o;
                e.v  = v;
                q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
        matrix_size = 2'($urandom); w_mat_idx = 4'($urandom); i_mat_idx = 4'($urandom);
    endtask

    // Wait for done, optionally re-pulsing start with other values while busy.
    task automatic finish_job(input int spur);
        int base, t;
        base = jobs_done;
        t = 1;
        while (jobs_done == base && t < 3000) begin
            if (t == spur) begin
                start = 1'b1; matrix_size = cur_sz ^ 2'b01;
                w_mat_idx = cur_wi ^ 4'hA; i_mat_idx = cur_ii ^ 4'h5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk(jobs_done != base, "job_complete", $sformatf("got=%0d exp=%0d", jobs_done, base + 1));
        chk(ostarts == 2 * cur_n - 1, "out_start_count", $sformatf("got=%0d exp=%0d", ostarts, 2 * cur_n - 1));
        @(negedge clk);
        chk(!busy && !w_rd && !i_rd && !out_start && !done, "idle_after_done",
            $sformatf("got busy=%0b w_rd=%0b i_rd=%0b out_start=%0b done=%0b exp=0",
                      busy, w_rd, i_rd, out_start, done));
    endtask

    task automatic run_job(input logic [1:0] sz, input logic [3:0] wi, input logic [3:0] ii,
                           input int spur, input bit hold40);
        ser_hold40 = hold40;
        launch(sz, wi, ii);
        finish_job(spur);
        ser_hold40 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, dr, spur;
        logic [1:0] sz;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk(all_zero(), "reset_outputs", "got=nonzero exp=0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk(all_zero(), "idle_no_start", $sformatf("got busy=%0b exp=0", busy));

        run_job(2'd0, 4'h3, 4'h5, 0, 1'b0);
        run_job(2'd3, 4'hF, 4'hF, 0, 1'b0);
        run_job(2'd0, 4'($urandom), 4'($urandom), 0, 1'b1);
        run_job(2'd1, 4'h2, 4'h9, 4 + 1, 1'b0);

        launch(2'd1, 4'h6, 4'h9);
        t = 0;
        while (ostarts < 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(ostarts >= 2, "reach_out", $sformatf("got=%0d exp>=2", ostarts));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        kill  = 1'b1;
        q.delete();
        #1 chk(all_zero(), "async_reset_outputs",
               $sformatf("got busy=%0b out_sel=%0d exp=0", busy, out_sel));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        kill  = 1'b0;
        repeat (4) @(negedge clk);
        chk(!done && !busy, "no_done_after_abort", $sformatf("got done=%0b busy=%0b exp=0", done, busy));
        run_job(2'd2, 4'hC, 4'h1, 0, 1'b0);

        for (int j = 0; j < 12; j++) begin
            sz   = 2'($urandom_range(0, 3));
            n    = 2 << sz;
            dr   = 2 * n - 1 + PE + SL;
            spur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * n + dr - 1)) : 0;
            run_job(sz, 4'($urandom), 4'($urandom), spur, 1'b0);
        end

        chk(q.size() == 0, "scoreboard_empty", $sformatf("got=%0d exp=0", q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
